// File: rtl/bcd_display_sched.sv
// ---------------------------------------------------------------------------
// bcd_display_sched
//
// Shares one external combinational 10-bit binary-to-BCD converter between
// three vending-machine value sources (credit, price, change).  Requests are
// arbitrated round-robin.  Each accepted value is converted and stored in a
// per-source 4-digit BCD buffer.  One selected buffer is time-multiplexed onto
// a 4-digit seven-segment display as an anode scan plus a BCD nibble.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   defined   : digits above the most significant nonzero digit of the
//               displayed buffer have their anode forced off (digit 0 is
//               never blanked).
//   undefined : all four digits are always driven.
//
// Parameters:
//   REFRESH_DIV : clock cycles each digit stays active (2 .. 2^20)
//   SCAN_W      : width of the refresh divider, must hold REFRESH_DIV-1
//
// Ports:
//   clk        in   1   system clock
//   reset      in   1   synchronous active-high reset
//   req_valid  in   3   update requests: bit0 credit, bit1 price, bit2 change
//   req_value  in  30   [9:0] credit, [19:10] price, [29:20] change
//   req_ready  out  3   one-hot accept strobe (combinational, IDLE only)
//   conv_bin   out 10   registered operand to the shared converter
//   conv_bcd   in  16   converter result, combinational from conv_bin
//   disp_sel   in   2   0 credit, 1 price, 2 change, 3 blank
//   an         out  4   active-low digit anodes, an[0] is the ones digit
//   seg_bcd    out  4   BCD nibble for the active digit
//   busy       out  1   high while a conversion is in flight
//
// Handshake: a transfer happens on a clock edge where req_valid[i] and
// req_ready[i] are both high.  The requester holds req_valid/req_value stable
// until it sees ready; req_value is sampled only at the transfer edge.  A
// request still valid after its accept counts as a new request.
// ---------------------------------------------------------------------------
module bcd_display_sched #(
  parameter int REFRESH_DIV = 50000,
  parameter int SCAN_W      = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req_valid,
  input  logic [29:0] req_value,
  output logic [2:0]  req_ready,
  output logic [9:0]  conv_bin,
  input  logic [15:0] conv_bcd,
  input  logic [1:0]  disp_sel,
  output logic [3:0]  an,
  output logic [3:0]  seg_bcd,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_CAPT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  state_t             r_state;
  logic [1:0]         r_rr_ptr;     // highest-priority source, 0..2
  logic [1:0]         r_idx;        // source of the conversion in flight
  logic [15:0]        r_buf_credit;
  logic [15:0]        r_buf_price;
  logic [15:0]        r_buf_change;
  logic [SCAN_W-1:0]  r_div;
  logic [1:0]         r_digit;

  // ---------------------------------------------------------------------
  // Round-robin arbitration
  // ---------------------------------------------------------------------
  logic [3:0]  w_valid4;            // padded so a 2-bit index is always legal
  logic [1:0]  w_ord0;
  logic [1:0]  w_ord1;
  logic [1:0]  w_ord2;
  logic        w_any;
  logic [1:0]  w_gidx;
  logic [9:0]  w_sel_value;
  logic [1:0]  w_next_ptr;

  always_comb begin
    w_valid4 = {1'b0, req_valid};

    // Search order starts at r_rr_ptr and wraps modulo 3.
    case (r_rr_ptr)
      2'd1: begin
        w_ord0 = 2'd1;
        w_ord1 = 2'd2;
        w_ord2 = 2'd0;
      end
      2'd2: begin
        w_ord0 = 2'd2;
        w_ord1 = 2'd0;
        w_ord2 = 2'd1;
      end
      default: begin
        w_ord0 = 2'd0;
        w_ord1 = 2'd1;
        w_ord2 = 2'd2;
      end
    endcase

    w_any  = 1'b1;
    w_gidx = 2'd0;
    if (w_valid4[w_ord0]) begin
      w_gidx = w_ord0;
    end else if (w_valid4[w_ord1]) begin
      w_gidx = w_ord1;
    end else if (w_valid4[w_ord2]) begin
      w_gidx = w_ord2;
    end else begin
      w_any = 1'b0;
    end

    case (w_gidx)
      2'd1:    w_sel_value = req_value[19:10];
      2'd2:    w_sel_value = req_value[29:20];
      default: w_sel_value = req_value[9:0];
    endcase

    w_next_ptr = (w_gidx == 2'd2) ? 2'd0 : (w_gidx + 2'd1);
  end

  // Ready is offered only in IDLE and never while reset is applied, so a
  // grant is never shown for an edge on which reset wins.
  always_comb begin
    req_ready = 3'b000;
    if ((r_state == S_IDLE) && !reset && w_any) begin
      req_ready = 3'b001 << w_gidx;
    end
  end

  // ---------------------------------------------------------------------
  // Conversion FSM: IDLE -> CONV (converter settles) -> CAPT (store result)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= 2'd0;
      r_idx        <= 2'd0;
      conv_bin     <= 10'd0;
      busy         <= 1'b0;
      r_buf_credit <= 16'h0000;
      r_buf_price  <= 16'h0000;
      r_buf_change <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          // In IDLE (reset low) any set valid bit is a transfer, since
          // ready is asserted for the granted bit in the same cycle.
          if (w_any) begin
            conv_bin <= w_sel_value;
            r_idx    <= w_gidx;
            r_rr_ptr <= w_next_ptr;
            busy     <= 1'b1;
            r_state  <= S_CONV;
          end else begin
            busy <= 1'b0;
          end
        end
        S_CONV: begin
          r_state <= S_CAPT;
        end
        S_CAPT: begin
          case (r_idx)
            2'd1:    r_buf_price  <= conv_bcd;
            2'd2:    r_buf_change <= conv_bcd;
            default: r_buf_credit <= conv_bcd;
          endcase
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Refresh divider and digit index; keeps running regardless of disp_sel.
  // ---------------------------------------------------------------------
  localparam logic [SCAN_W-1:0] DIV_LAST = SCAN_W'(REFRESH_DIV - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div   <= '0;
      r_digit <= 2'd0;
    end else if (r_div == DIV_LAST) begin
      r_div   <= '0;
      r_digit <= r_digit + 2'd1;
    end else begin
      r_div <= r_div + SCAN_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Display path, combinational on disp_sel so a switch shows immediately.
  // ---------------------------------------------------------------------
  logic [15:0] w_disp_buf;
  logic [3:0]  w_nibble;
  logic        w_blank;

  always_comb begin
    case (disp_sel)
      2'd0:    w_disp_buf = r_buf_credit;
      2'd1:    w_disp_buf = r_buf_price;
      2'd2:    w_disp_buf = r_buf_change;
      default: w_disp_buf = 16'h0000;
    endcase

    case (r_digit)
      2'd1:    w_nibble = w_disp_buf[7:4];
      2'd2:    w_nibble = w_disp_buf[11:8];
      2'd3:    w_nibble = w_disp_buf[15:12];
      default: w_nibble = w_disp_buf[3:0];
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Index of the most significant nonzero digit; 0 when the value is 0 so
  // that digit 0 always remains lit.
  logic [1:0] w_msd;

  always_comb begin
    if (w_disp_buf[15:12] != 4'd0) begin
      w_msd = 2'd3;
    end else if (w_disp_buf[11:8] != 4'd0) begin
      w_msd = 2'd2;
    end else if (w_disp_buf[7:4] != 4'd0) begin
      w_msd = 2'd1;
    end else begin
      w_msd = 2'd0;
    end
    w_blank = (r_digit > w_msd);
  end
`else
  always_comb begin
    w_blank = 1'b0;
  end
`endif

  always_comb begin
    if ((disp_sel == 2'd3) || w_blank) begin
      an = 4'b1111;
    end else begin
      an = ~(4'b0001 << r_digit);
    end
    seg_bcd = (disp_sel == 2'd3) ? 4'd0 : w_nibble;
  end

endmodule

// File: tb/tb_bcd_display_sched.sv
// ---------------------------------------------------------------------------
// tb_bcd_display_sched
//
// Directed bench for bcd_display_sched with REFRESH_DIV=4.  The shared
// converter is modelled here as a behavioural binary-to-BCD function.  A
// small scan model tracks which digit should be active; expected buffer
// contents are hand-written constants.
// ---------------------------------------------------------------------------
module tb_bcd_display_sched;

  localparam int RD = 4;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset;
  logic [2:0]  req_valid;
  logic [29:0] req_value;
  logic [2:0]  req_ready;
  logic [9:0]  conv_bin;
  logic [15:0] conv_bcd;
  logic [1:0]  disp_sel;
  logic [3:0]  an;
  logic [3:0]  seg_bcd;
  logic        busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "bench timeout");
  end

  bcd_display_sched #(
    .REFRESH_DIV(RD),
    .SCAN_W(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_value(req_value),
    .req_ready(req_ready),
    .conv_bin(conv_bin),
    .conv_bcd(conv_bcd),
    .disp_sel(disp_sel),
    .an(an),
    .seg_bcd(seg_bcd),
    .busy(busy)
  );

  // Behavioural converter
  function automatic logic [15:0] bin2bcd(input logic [9:0] v);
    int x;
    x = int'(v);
    return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  assign conv_bcd = bin2bcd(conv_bin);

  // Scan model: expected active digit
  int m_div;
  int m_dig;

  always @(posedge clk) begin
    if (reset) begin
      m_div <= 0;
      m_dig <= 0;
    end else if (m_div == RD - 1) begin
      m_div <= 0;
      m_dig <= (m_dig + 1) % 4;
    end else begin
      m_div <= m_div + 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_buf [3];
  int checks;
  int failures;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag);
    logic [15:0] b;
    logic [3:0]  e_an;
    logic [3:0]  e_seg;
    int          msd;
    if (disp_sel == 2'd3) begin
      e_an  = 4'b1111;
      e_seg = 4'd0;
    end else begin
      b     = exp_buf[disp_sel];
      e_seg = 4'((b >> (4 * m_dig)) & 16'hF);
      e_an  = ~(4'b0001 << m_dig);
`ifdef LEADING_ZERO_BLANK_EN
      msd = 0;
      for (int d = 1; d < 4; d++) begin
        if (((b >> (4 * d)) & 16'hF) != 16'd0) msd = d;
      end
      if (m_dig > msd) e_an = 4'b1111;
`else
      msd = 0;
`endif
    end
    chk({tag, "_an"}, {12'd0, an}, {12'd0, e_an});
    chk({tag, "_seg"}, {12'd0, seg_bcd}, {12'd0, e_seg});
  endtask

  task automatic scan_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk_disp(tag);
      tick();
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 3; i++) exp_buf[i] = 16'h0000;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    req_valid = 3'b000;
    req_value = 30'd0;
    disp_sel  = 2'd0;
    clear_exp();

    // Reset state
    tick();
    tick();
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_ready", {13'd0, req_ready}, 16'd0);
    chk("rst_conv_bin", {6'd0, conv_bin}, 16'd0);
    chk("rst_an", {12'd0, an}, 16'h000E);
    chk("rst_seg", {12'd0, seg_bcd}, 16'd0);

    // Credit 345
    reset = 1'b0;
    req_valid = 3'b001;
    req_value[9:0] = 10'd345;
    #1;
    chk("t1_ready", {13'd0, req_ready}, 16'h0001);
    tick();
    chk("t1_busy_c1", {15'd0, busy}, 16'd1);
    chk("t1_conv_bin", {6'd0, conv_bin}, 16'd345);
    req_valid = 3'b000;
    tick();
    chk("t1_busy_c2", {15'd0, busy}, 16'd1);
    tick();
    chk("t1_busy_done", {15'd0, busy}, 16'd0);
    exp_buf[0] = 16'h0345;
    chk_disp("t1_next_cycle");
    scan_check("t1_scan", 16);

    // All three sources held continuously
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_exp();
    req_value = {10'd1023, 10'd250, 10'd12};
    req_valid = 3'b111;
    #1;
    chk("t2_grant0", {13'd0, req_ready}, 16'h0001);
    tick();
    chk("t2_gap0a", {13'd0, req_ready}, 16'h0000);
    tick();
    chk("t2_gap0b", {13'd0, req_ready}, 16'h0000);
    tick();
    chk("t2_grant1", {13'd0, req_ready}, 16'h0002);
    tick();
    chk("t2_gap1a", {13'd0, req_ready}, 16'h0000);
    tick();
    chk("t2_gap1b", {13'd0, req_ready}, 16'h0000);
    tick();
    chk("t2_grant2", {13'd0, req_ready}, 16'h0004);
    tick();
    req_valid = 3'b000;
    tick();
    tick();
    exp_buf[0] = 16'h0012;
    exp_buf[1] = 16'h0250;
    exp_buf[2] = 16'h1023;
    disp_sel = 2'd0;
    #1;
    scan_check("t2_buf0", 16);
    disp_sel = 2'd1;
    #1;
    scan_check("t2_buf1", 16);
    disp_sel = 2'd2;
    #1;
    scan_check("t2_buf2", 16);

    // Price 999, value changed after accept
    disp_sel = 2'd1;
    req_valid = 3'b010;
    req_value[19:10] = 10'd999;
    #1;
    chk("t3_ready", {13'd0, req_ready}, 16'h0002);
    tick();
    req_value[19:10] = 10'd0;
    tick();
    tick();
    exp_buf[1] = 16'h0999;
    chk_disp("t3_next_cycle");
    chk("t3_reaccept", {13'd0, req_ready}, 16'h0002);
    req_valid = 3'b000;
    #1;
    chk("t3_no_accept", {13'd0, req_ready}, 16'h0000);
    tick();
    chk("t3_idle_busy", {15'd0, busy}, 16'd0);
    scan_check("t3_buf1", 16);

    // Change 77 with reset during CONV
    disp_sel = 2'd2;
    req_valid = 3'b100;
    req_value[29:20] = 10'd77;
    #1;
    chk("t4_ready", {13'd0, req_ready}, 16'h0004);
    tick();
    reset = 1'b1;
    #1;
    chk("t4_busy_conv", {15'd0, busy}, 16'd1);
    chk("t4_ready_rst", {13'd0, req_ready}, 16'h0000);
    tick();
    clear_exp();
    chk("t4_busy_rst", {15'd0, busy}, 16'd0);
    chk("t4_conv_bin_rst", {6'd0, conv_bin}, 16'd0);
    chk_disp("t4_buf2_zero");
    reset = 1'b0;
    #1;
    chk("t4_reaccept", {13'd0, req_ready}, 16'h0004);
    tick();
    req_valid = 3'b000;
    tick();
    tick();
    exp_buf[2] = 16'h0077;
    scan_check("t4_buf2", 16);

    // Blank selection, then switch to change
    disp_sel = 2'd3;
    #1;
    scan_check("t5_blank", 8);
    disp_sel = 2'd2;
    #1;
    chk_disp("t5_switch");

    // Credit 7, then value 0 (leading-zero behaviour depends on build)
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_exp();
    disp_sel = 2'd0;
    req_valid = 3'b001;
    req_value[9:0] = 10'd7;
    tick();
    req_valid = 3'b000;
    tick();
    tick();
    exp_buf[0] = 16'h0007;
    scan_check("t6_seven", 16);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_exp();
    #1;
    scan_check("t6_zero", 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
